apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge_if.sv | 27 ++
 rtl/apb_master_bridge.sv | 121 ++++++++++++
 tb/tb_apb_master_bridge.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// APB bus between one bridge master and NUM_SLV slaves.
// The per-slave return lanes are flattened, with slave i at [i*DW +: DW].
interface apb_master_bridge_if #(
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int NUM_SLV = 2
);
  logic [NUM_SLV-1:0]    psel;
  logic                  penable;
  logic                  pwrite;
  logic [AW-1:0]         paddr;
  logic [DW-1:0]         pwdata;
  logic [DW/8-1:0]       pstrb;
  logic [NUM_SLV*DW-1:0] prdata;
  logic [NUM_SLV-1:0]    pready;
  logic [NUM_SLV-1:0]    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Command-to-APB master bridge: IDLE/SETUP/ACCESS sequencer with slave decode,
// back-to-back chaining and an ACCESS wait-state timeout.
module apb_master_bridge #(
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int NUM_SLV = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                transfer,
  input  logic                read_write,
  input  logic [AW-1:0]       apb_write_paddr,
  input  logic [DW-1:0]       apb_write_data,
  input  logic [DW/8-1:0]     apb_write_strb,
  input  logic [AW-1:0]       apb_read_paddr,
  output logic [DW-1:0]       apb_read_data_out,
  output logic                done,
  output logic                err,
  output logic                busy,
  apb_master_bridge_if.master apb
);
  localparam int         SB        = $clog2(NUM_SLV);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e        state_q, state_d;
  logic [SB-1:0] slv_q;
  logic [7:0]    wait_q;
  logic [AW-1:0] cmd_addr;
  logic          sel_ready, sel_err;
  logic [DW-1:0] sel_rdata;
  logic          latch_cmd, complete, timeout;

  assign cmd_addr  = read_write ? apb_read_paddr : apb_write_paddr;

  // Only the latched slave's return lanes can influence the transfer.
  assign sel_ready = apb.pready[slv_q];
  assign sel_err   = apb.pslverr[slv_q];
  assign sel_rdata = apb.prdata[slv_q*DW +: DW];

  assign busy        = (state_q != IDLE);
  assign apb.psel    = (state_q == IDLE) ? '0 : (NUM_SLV'(1) << slv_q);
  assign apb.penable = (state_q == ACCESS);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    latch_cmd = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          latch_cmd = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          complete = 1'b1;
          if (transfer) begin
            latch_cmd = 1'b1;
            state_d   = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else if (wait_q == WAIT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      slv_q      <= '0;
      apb.pwrite <= 1'b0;
      apb.paddr  <= '0;
      apb.pwdata <= '0;
      apb.pstrb  <= '0;
    end else if (latch_cmd) begin
      slv_q      <= cmd_addr[AW-1 -: SB];
      apb.pwrite <= ~read_write;
      apb.paddr  <= cmd_addr;
      apb.pwdata <= apb_write_data;
      apb.pstrb  <= read_write ? '0 : apb_write_strb;
    end
  end

  // ACCESS is only ever entered from SETUP, so clearing in SETUP clears on entry.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)                            wait_q <= '0;
    else if (state_q == SETUP)               wait_q <= '0;
    else if (state_q == ACCESS && !sel_ready) wait_q <= wait_q + 8'd1;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      done              <= 1'b0;
      err               <= 1'b0;
      apb_read_data_out <= '0;
    end else begin
      done <= complete | timeout;
      err  <= (complete & sel_err) | timeout;
      if (complete && !apb.pwrite) apb_read_data_out <= sel_rdata;
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: per-transaction timeline model,
// noisy unselected slaves, chaining, timeout and mid-transfer reset.
module tb_apb_master_bridge;
  localparam int AW      = 9;
  localparam int DW      = 8;
  localparam int NUM_SLV = 2;
  localparam int SB      = 1;
  localparam int TIMEOUT = 4;

  typedef struct {
    bit                rw;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     raddr;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   strb;
    int                waits;
    bit                slverr;
    logic [DW-1:0]     rdata;
  } cmd_t;

  logic            pclk = 1'b0;
  logic            presetn;
  logic            transfer, read_write;
  logic [AW-1:0]   apb_write_paddr, apb_read_paddr;
  logic [DW-1:0]   apb_write_data;
  logic [DW/8-1:0] apb_write_strb;
  logic [DW-1:0]   apb_read_data_out;
  logic            done, err, busy;

  apb_master_bridge_if #(.AW(AW), .DW(DW), .NUM_SLV(NUM_SLV)) apb ();

  apb_master_bridge #(.AW(AW), .DW(DW), .NUM_SLV(NUM_SLV), .TIMEOUT(TIMEOUT)) dut (
    .pclk              (pclk),
    .presetn           (presetn),
    .transfer          (transfer),
    .read_write        (read_write),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_write_strb    (apb_write_strb),
    .apb_read_paddr    (apb_read_paddr),
    .apb_read_data_out (apb_read_data_out),
    .done              (done),
    .err               (err),
    .busy              (busy),
    .apb               (apb)
  );

  always #5 pclk = ~pclk;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] model_rdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sel_of(input cmd_t c);
    logic [AW-1:0] a;
    a = c.rw ? c.raddr : c.waddr;
    return int'(a >> (AW - SB));
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.rw     = 1'($urandom);
    c.waddr  = AW'($urandom);
    c.raddr  = AW'($urandom);
    c.wdata  = DW'($urandom);
    c.strb   = (DW/8)'($urandom);
    c.waits  = int'($urandom_range(0, TIMEOUT + 1));
    c.slverr = 1'($urandom);
    c.rdata  = DW'($urandom);
    return c;
  endfunction

  task automatic drive_cmd(input cmd_t c);
    transfer        = 1'b1;
    read_write      = c.rw;
    apb_write_paddr = c.waddr;
    apb_read_paddr  = c.raddr;
    apb_write_data  = c.wdata;
    apb_write_strb  = c.strb;
  endtask

  // Garbage on the command inputs while a transfer is in flight.
  task automatic scramble();
    transfer        = 1'($urandom);
    read_write      = 1'($urandom);
    apb_write_paddr = AW'($urandom);
    apb_read_paddr  = AW'($urandom);
    apb_write_data  = DW'($urandom);
    apb_write_strb  = (DW/8)'($urandom);
  endtask

  task automatic drive_slaves(input int sel, input logic rdy, input logic serr, input logic [DW-1:0] rd);
    apb.pready  = NUM_SLV'($urandom);
    apb.pslverr = NUM_SLV'($urandom);
    apb.prdata  = (NUM_SLV*DW)'($urandom);
    apb.pready[sel]            = rdy;
    apb.pslverr[sel]           = serr;
    apb.prdata[sel*DW +: DW]   = rd;
  endtask

  task automatic check_bus(input string ph, input cmd_t c, input bit en);
    check({ph, ".psel"},    32'(apb.psel),    32'(1) << sel_of(c));
    check({ph, ".penable"}, 32'(apb.penable), 32'(en));
    check({ph, ".paddr"},   32'(apb.paddr),   32'(c.rw ? c.raddr : c.waddr));
    check({ph, ".pwrite"},  32'(apb.pwrite),  32'(!c.rw));
    check({ph, ".pwdata"},  32'(apb.pwdata),  32'(c.wdata));
    check({ph, ".pstrb"},   32'(apb.pstrb),   c.rw ? 32'd0 : 32'(c.strb));
    check({ph, ".busy"},    32'(busy),        32'd1);
  endtask

  // One command from latch to done. Called just after a negedge; when
  // chained_in, the command was latched on the edge just passed.
  task automatic run(input cmd_t c, input bit chained_in, input bit chain_out, input cmd_t nxt);
    int sel;
    bit to;
    sel = sel_of(c);
    to  = (c.waits >= TIMEOUT);
    if (!chained_in) begin
      drive_cmd(c);
      @(posedge pclk); @(negedge pclk);
    end
    check_bus("setup", c, 1'b0);
    scramble();
    drive_slaves(sel, 1'($urandom), 1'($urandom), DW'($urandom));
    for (int w = 0; w <= TIMEOUT; w++) begin
      @(posedge pclk); @(negedge pclk);
      check_bus("access", c, 1'b1);
      check("access.done", 32'(done), 32'd0);
      if (to && w == TIMEOUT - 1) begin
        scramble();
        transfer = 1'b0;
        drive_slaves(sel, 1'b0, 1'($urandom), DW'($urandom));
        break;
      end
      if (!to && w == c.waits) begin
        if (chain_out) drive_cmd(nxt);
        else begin
          scramble();
          transfer = 1'b0;
        end
        drive_slaves(sel, 1'b1, c.slverr, c.rdata);
        break;
      end
      scramble();
      drive_slaves(sel, 1'b0, 1'($urandom), DW'($urandom));
    end
    @(posedge pclk); @(negedge pclk);
    if (!to && c.rw) model_rdata = c.rdata;
    check("done",  32'(done), 32'd1);
    check("err",   32'(err),  to ? 32'd1 : 32'(c.slverr));
    check("rdata", 32'(apb_read_data_out), 32'(model_rdata));
    check("busy",  32'(busy), 32'(chain_out));
    if (!chain_out) begin
      check("idle.psel",    32'(apb.psel),    32'd0);
      check("idle.penable", 32'(apb.penable), 32'd0);
      @(posedge pclk); @(negedge pclk);
      check("done.clear", 32'(done), 32'd0);
      check("idle.busy",  32'(busy), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string ph);
    check({ph, ".psel"},    32'(apb.psel),    32'd0);
    check({ph, ".penable"}, 32'(apb.penable), 32'd0);
    check({ph, ".pwrite"},  32'(apb.pwrite),  32'd0);
    check({ph, ".paddr"},   32'(apb.paddr),   32'd0);
    check({ph, ".pwdata"},  32'(apb.pwdata),  32'd0);
    check({ph, ".pstrb"},   32'(apb.pstrb),   32'd0);
    check({ph, ".rdata"},   32'(apb_read_data_out), 32'd0);
    check({ph, ".done"},    32'(done), 32'd0);
    check({ph, ".err"},     32'(err),  32'd0);
    check({ph, ".busy"},    32'(busy), 32'd0);
  endtask

  initial begin
    cmd_t c, nxt;
    bit   chained, ch;

    presetn  = 1'b0;
    transfer = 1'b0;
    scramble();
    transfer = 1'b0;
    drive_slaves(0, 1'b0, 1'b0, '0);
    #1;
    check_all_zero("reset");
    @(negedge pclk); @(negedge pclk);
    presetn = 1'b1;

    // Zero-wait write to slave 1.
    c = rand_cmd();
    c.rw = 1'b0; c.waddr = 9'h105; c.wdata = 8'hA5; c.strb = 1'b1; c.waits = 0; c.slverr = 1'b0;
    run(c, 1'b0, 1'b0, c);

    // Read from slave 0 with two wait states.
    c = rand_cmd();
    c.rw = 1'b1; c.raddr = 9'h023; c.waits = 2; c.slverr = 1'b0; c.rdata = 8'h3C;
    run(c, 1'b0, 1'b0, c);
    check("read.0x3C", 32'(apb_read_data_out), 32'h3C);

    // Slave error on a write.
    c = rand_cmd();
    c.rw = 1'b0; c.waits = 1; c.slverr = 1'b1;
    run(c, 1'b0, 1'b0, c);

    // Slave never ready: abort after TIMEOUT ACCESS cycles.
    c = rand_cmd();
    c.waits = TIMEOUT;
    run(c, 1'b0, 1'b0, c);

    // Back-to-back write then read.
    c = rand_cmd();
    c.rw = 1'b0; c.waits = 0;
    nxt = rand_cmd();
    nxt.rw = 1'b1; nxt.waits = 1;
    run(c, 1'b0, 1'b1, nxt);
    run(nxt, 1'b1, 1'b0, nxt);

    // Reset in the middle of an ACCESS phase.
    c = rand_cmd();
    c.rw = 1'b0; c.waddr = 9'h1FF; c.wdata = 8'hFF; c.strb = 1'b1;
    drive_cmd(c);
    @(posedge pclk); @(negedge pclk);
    transfer = 1'b0;
    drive_slaves(sel_of(c), 1'b0, 1'b0, '0);
    @(posedge pclk); @(negedge pclk);
    check("pre_reset.penable", 32'(apb.penable), 32'd1);
    #2 presetn = 1'b0;
    #1 check_all_zero("midreset");
    model_rdata = '0;
    @(negedge pclk);
    presetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); @(negedge pclk);
      check("post_reset.done", 32'(done), 32'd0);
      check("post_reset.busy", 32'(busy), 32'd0);
    end

    // Random traffic with random chaining.
    chained = 1'b0;
    c = rand_cmd();
    for (int i = 0; i < 60; i++) begin
      nxt = rand_cmd();
      ch  = (i < 59) && (c.waits < TIMEOUT) && 1'($urandom);
      run(c, chained, ch, nxt);
      chained = ch;
      c = nxt;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
